// File: rtl/systolic_pkg.sv
`default_nettype none
//==============================================================================
// Module   : systolic_pkg
// Desc     : Shared state encoding and helpers for the systolic output path
//            (sequencer, output regfile, recompute-unit glue).
// Revision : 1.0 - initial release
//==============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SKEW   = 3'd1,
        S_SWEEP  = 3'd2,
        S_RECOMP = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

    // The regfile has no write enable; index COLS addresses no entry.
    function automatic int unsigned park_idx(input int unsigned cols);
        return cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_output_seq.sv
`default_nettype none
//==============================================================================
// Module   : systolic_output_seq
// Desc     : Captures skewed systolic-array bottom outputs into the output
//            regfile one column per cycle, skipping a BIST-faulty column and
//            patching it later from the BISR recompute unit.
// Revision : 1.0 - initial release
//==============================================================================
module systolic_output_seq
    import systolic_pkg::*;
#(
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int LATENCY     = 4,
    parameter int TIMEOUT     = 64,
    parameter int FAULT_COL_W = $clog2(COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      fault_valid,
    input  logic [FAULT_COL_W-1:0]    fault_col,
    input  logic [COLS*WORD_SIZE-1:0] bottom_out,
    input  logic [WORD_SIZE-1:0]      recomp_data,
    input  logic                      recomp_valid,
    output logic [COLS*WORD_SIZE-1:0] wr_data,
    output logic [COLS-1:0]           wr_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int C_CNT_W  = $clog2(LATENCY + 1);
    localparam int C_TCNT_W = $clog2(TIMEOUT + 1);
    localparam int C_COL_W  = $clog2(COLS + 1);

    localparam logic [C_CNT_W-1:0]  C_LAT      = C_CNT_W'(LATENCY);
    localparam logic [C_TCNT_W-1:0] C_TMO      = C_TCNT_W'(TIMEOUT);
    localparam logic [C_COL_W-1:0]  C_LAST_COL = C_COL_W'(COLS - 1);
    localparam logic [COLS-1:0]     C_PARK     = COLS'(park_idx(COLS));

    seq_state_t                r_state, w_state_nxt;
    logic [C_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [C_TCNT_W-1:0]       r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic [C_COL_W-1:0]        r_col, w_col_nxt;
    logic                      r_fault_v, w_fault_v_nxt;
    logic [C_COL_W-1:0]        r_fault_col, w_fault_col_nxt;
    logic [COLS*WORD_SIZE-1:0] w_wr_data_nxt, w_recomp_bus;
    logic [COLS-1:0]           w_wr_idx_nxt;
    logic                      w_done_nxt, w_err_nxt;
    logic                      w_fault_ok;

    assign busy       = (r_state != S_IDLE);
    assign w_tcnt_inc = r_tcnt + C_TCNT_W'(1);
    // Out-of-range fault indices from BIST are treated as no fault at all.
    assign w_fault_ok = fault_valid && (int'(fault_col) < COLS);

    always_comb begin
        w_recomp_bus = '0;
        for (int i = 0; i < COLS; i++) begin
            if (r_fault_col == C_COL_W'(i)) begin
                w_recomp_bus[i*WORD_SIZE +: WORD_SIZE] = recomp_data;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tcnt_nxt      = r_tcnt;
        w_col_nxt       = r_col;
        w_fault_v_nxt   = r_fault_v;
        w_fault_col_nxt = r_fault_col;
        w_wr_data_nxt   = wr_data;
        w_wr_idx_nxt    = C_PARK;
        w_done_nxt      = 1'b0;
        w_err_nxt       = err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_fault_v_nxt   = w_fault_ok;
                    w_fault_col_nxt = C_COL_W'(fault_col);
                    w_cnt_nxt       = C_CNT_W'(1);
                    w_err_nxt       = 1'b0;
                    w_state_nxt     = S_SKEW;
                end
            end

            S_SKEW: begin
                if (r_cnt == C_LAT) begin
                    w_col_nxt   = '0;
                    w_state_nxt = S_SWEEP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end

            S_SWEEP: begin
                w_wr_data_nxt = bottom_out;
                w_wr_idx_nxt  = (r_fault_v && (r_col == r_fault_col)) ? C_PARK : COLS'(r_col);
                w_col_nxt     = r_col + C_COL_W'(1);
                if (r_col == C_LAST_COL) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = r_fault_v ? S_RECOMP : S_DONE;
                end
            end

            S_RECOMP: begin
                w_tcnt_nxt = w_tcnt_inc;
                // A result arriving on the final allowed cycle still wins over the timeout.
                if (recomp_valid) begin
                    w_wr_data_nxt = w_recomp_bus;
                    w_wr_idx_nxt  = COLS'(r_fault_col);
                    w_state_nxt   = S_DONE;
                end else if (w_tcnt_inc == C_TMO) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_col       <= '0;
            r_fault_v   <= 1'b0;
            r_fault_col <= '0;
            wr_data     <= '0;
            wr_idx      <= C_PARK;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_col       <= w_col_nxt;
            r_fault_v   <= w_fault_v_nxt;
            r_fault_col <= w_fault_col_nxt;
            wr_data     <= w_wr_data_nxt;
            wr_idx      <= w_wr_idx_nxt;
            done        <= w_done_nxt;
            err         <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_output_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_systolic_output_seq
// Desc     : Self-checking bench: directed vector table plus randomized runs
//            against a cycle-offset model of the capture schedule.
// Revision : 1.0 - initial release
//==============================================================================
module tb_systolic_output_seq;

    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int LAT  = 4;
    localparam int TMO  = 64;
    localparam int FCW  = 3;
    localparam int IW   = $clog2(COLS);
    localparam int BUS  = COLS * W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           fault_valid;
    logic [FCW-1:0] fault_col;
    logic [BUS-1:0] bottom_out;
    logic [W-1:0]   recomp_data;
    logic           recomp_valid;
    logic [BUS-1:0] wr_data;
    logic [COLS-1:0] wr_idx;
    logic           busy;
    logic           done;
    logic           err;

    systolic_output_seq #(
        .COLS(COLS), .WORD_SIZE(W), .LATENCY(LAT), .TIMEOUT(TMO), .FAULT_COL_W(FCW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .fault_valid(fault_valid),
        .fault_col(fault_col), .bottom_out(bottom_out), .recomp_data(recomp_data),
        .recomp_valid(recomp_valid), .wr_data(wr_data), .wr_idx(wr_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fv;
        int fc;
        int rk;       // offset of the edge sampling recomp_valid, -1 = never
        bit spam;     // re-assert start and pulse recomp_valid while sweeping
        bit idle_rv;  // pulse recomp_valid while idle before start
        int rst_at;   // offset of the edge sampling rst, -1 = never
        int kdone;    // offset at which done is visible
        bit err_end;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic         rf_clr;
    logic [W-1:0] rf_dut [COLS];
    logic [W-1:0] rf_exp [COLS];
    logic [BUS-1:0] bo_hist [0:127];
    logic [W-1:0]   rd_hist [0:127];
    bit exp_err_prev;

    // Stand-in for the output regfile: writes whatever index the sequencer presents.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < COLS; i++) rf_dut[i] <= '0;
        end else if (wr_idx < COLS) begin
            rf_dut[wr_idx[IW-1:0]] <= wr_data[wr_idx[IW-1:0]*W +: W];
        end
    end

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @k=%0d: got %h, want %h", name, k, act, exp);
        end
    endtask

    function automatic int model_kdone(input bit fv, input int fc, input int rk);
        if (!(fv && fc < COLS)) return LAT + COLS + 1;
        if (rk >= LAT + COLS + 1 && rk <= LAT + COLS + TMO) return rk + 1;
        return LAT + COLS + TMO + 1;
    endfunction

    function automatic bit model_err(input bit fv, input int fc, input int rk);
        if (!(fv && fc < COLS)) return 1'b0;
        return !(rk >= LAT + COLS + 1 && rk <= LAT + COLS + TMO);
    endfunction

    task automatic idle_check(input int k);
        chk("idle_wr_idx", k, 64'(wr_idx), 64'(COLS));
        chk("idle_busy", k, 64'(busy), 64'd0);
        chk("idle_done", k, 64'(done), 64'd0);
        chk("idle_err", k, 64'(err), 64'(exp_err_prev));
    endtask

    task automatic run_op(input vec_t v);
        bit f_eff = v.fv && (v.fc < COLS);
        int kend = (v.rst_at >= 0) ? v.rst_at : v.kdone + 1;
        int exp_idx;
        logic [BUS-1:0] exp_bus;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_check(-2 + i);
            recomp_valid = v.idle_rv;
            recomp_data  = W'($urandom);
        end
        @(negedge clk);
        idle_check(-1);
        start        = 1'b1;
        fault_valid  = v.fv;
        fault_col    = FCW'(v.fc);
        recomp_valid = 1'b0;
        bottom_out   = {$urandom, $urandom};

        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            if (v.rst_at >= 0 && k == v.rst_at) begin
                chk("rst_wr_idx", k, 64'(wr_idx), 64'(COLS));
                chk("rst_busy", k, 64'(busy), 64'd0);
                chk("rst_done", k, 64'(done), 64'd0);
                chk("rst_err", k, 64'(err), 64'd0);
                exp_err_prev = 1'b0;
            end else begin
                exp_idx = COLS;
                exp_bus = '0;
                if (k >= LAT + 1 && k <= LAT + COLS && !(f_eff && (k - LAT - 1) == v.fc)) begin
                    exp_idx = k - LAT - 1;
                    exp_bus = bo_hist[k];
                end
                if (f_eff && k == v.rk) begin
                    exp_idx = v.fc;
                    exp_bus[v.fc*W +: W] = rd_hist[k];
                end
                chk("wr_idx", k, 64'(wr_idx), 64'(exp_idx));
                if (exp_idx < COLS) begin
                    chk("wr_data", k, 64'(wr_data), 64'(exp_bus));
                    rf_exp[exp_idx] = exp_bus[exp_idx*W +: W];
                end
                chk("busy", k, 64'(busy), 64'(k < v.kdone));
                chk("done", k, 64'(done), 64'(k == v.kdone));
                chk("err", k, 64'(err), 64'(v.err_end && k >= v.kdone - 1));
                if (k == kend) exp_err_prev = v.err_end;
            end
            if (k < kend) begin
                start        = v.spam && (k + 1 <= LAT + COLS);
                fault_valid  = 1'($urandom);
                fault_col    = FCW'($urandom);
                bottom_out   = {$urandom, $urandom};
                bo_hist[k+1] = bottom_out;
                recomp_data  = W'($urandom);
                rd_hist[k+1] = recomp_data;
                recomp_valid = (k + 1 == v.rk) || (v.spam && k + 1 == LAT + 2);
                rst          = (k + 1 == v.rst_at);
            end else begin
                start        = 1'b0;
                recomp_valid = 1'b0;
                rst          = 1'b0;
            end
        end
        for (int i = 0; i < COLS; i++) chk("regfile", i, 64'(rf_dut[i]), 64'(rf_exp[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        vec_t rv;

        tbl[0] = '{1'b0, 0, -1, 1'b0, 1'b0, -1,  9, 1'b0};  // plain sweep
        tbl[1] = '{1'b1, 2, 11, 1'b0, 1'b0, -1, 12, 1'b0};  // recompute 3 cycles late
        tbl[2] = '{1'b1, 1, -1, 1'b0, 1'b0, -1, 73, 1'b1};  // recompute timeout
        tbl[3] = '{1'b0, 0, -1, 1'b1, 1'b1, -1,  9, 1'b0};  // ignored start/recomp, clears err
        tbl[4] = '{1'b0, 0, -1, 1'b0, 1'b0,  7,  9, 1'b0};  // reset after idx 1 shown
        tbl[5] = '{1'b0, 0, -1, 1'b0, 1'b0, -1,  9, 1'b0};  // normal after reset
        tbl[6] = '{1'b1, 5, -1, 1'b0, 1'b0, -1,  9, 1'b0};  // out-of-range fault
        tbl[7] = '{1'b1, 0,  9, 1'b0, 1'b0, -1, 10, 1'b0};  // earliest recompute
        tbl[8] = '{1'b1, 3, 72, 1'b0, 1'b0, -1, 73, 1'b0};  // recompute on last cycle
        tbl[9] = '{1'b1, 3, 12, 1'b1, 1'b0, -1, 13, 1'b0};  // noise with a fault

        rst = 1'b1; start = 1'b0; fault_valid = 1'b0; fault_col = '0;
        bottom_out = '0; recomp_data = '0; recomp_valid = 1'b0; rf_clr = 1'b1;
        exp_err_prev = 1'b0;
        for (int i = 0; i < COLS; i++) rf_exp[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_wr_idx", 0, 64'(wr_idx), 64'(COLS));
        chk("reset_wr_data", 0, 64'(wr_data), 64'd0);
        chk("reset_busy", 0, 64'(busy), 64'd0);
        chk("reset_done", 0, 64'(done), 64'd0);
        chk("reset_err", 0, 64'(err), 64'd0);
        rst = 1'b0;
        rf_clr = 1'b0;

        for (int t = 0; t < 10; t++) run_op(tbl[t]);

        for (int r = 0; r < 20; r++) begin
            rv.fv      = 1'($urandom_range(0, 1));
            rv.fc      = int'($urandom_range(0, 5));
            rv.rk      = ($urandom_range(0, 3) == 0) ? -1 :
                         LAT + COLS + int'(($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO)
                                                                       : $urandom_range(1, 8));
            rv.spam    = 1'($urandom_range(0, 1));
            rv.idle_rv = 1'($urandom_range(0, 1));
            rv.rst_at  = -1;
            rv.kdone   = model_kdone(rv.fv, rv.fc, rv.rk);
            rv.err_end = model_err(rv.fv, rv.fc, rv.rk);
            run_op(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
